// File: rtl/quat_requant_stage.sv
// quat_requant_stage: requantizes a Q2.30 quaternion to Q1.15 with rounding and saturation.
// Two-stage valid/ready pipeline with full backpressure. S1 holds the rounded and shifted value
// (IN_W+1 bits). S2 holds the saturated result and drives the outputs.
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   in_valid/in_ready        input handshake; in_ready = !out_valid || out_ready
//   in_q0..in_q3             signed IN_W-bit input components
//   out_valid/out_ready      output handshake
//   out_q0..out_q3           signed OUT_W-bit requantized components
//   out_sat[3:0]             per-component saturation flags, aligned with out_q*
//   sat_sticky, sat_clr      OR of out_sat over out transfers, and its synchronous clear
//   sat_count                (only with QREQ_SAT_COUNT_EN) saturating count of saturated components
module quat_requant_stage #(
   parameter int IN_W     = 32,
   parameter int OUT_W    = 16,
   parameter int SHIFT    = 15,
   parameter int ROUND_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_q0,
   input  logic [IN_W-1:0]  in_q1,
   input  logic [IN_W-1:0]  in_q2,
   input  logic [IN_W-1:0]  in_q3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_q0,
   output logic [OUT_W-1:0] out_q1,
   output logic [OUT_W-1:0] out_q2,
   output logic [OUT_W-1:0] out_q3,
   output logic [3:0]       out_sat,
   output logic             sat_sticky,
   input  logic             sat_clr
`ifdef QREQ_SAT_COUNT_EN
   ,
   output logic [15:0]      sat_count
`endif
);
   localparam logic signed [IN_W:0] RND  = (ROUND_EN != 0) ? ((IN_W+1)'(1) << (SHIFT-1)) : '0;
   localparam logic signed [IN_W:0] YMAX = (IN_W+1)'((1 << (OUT_W-1)) - 1);
   localparam logic signed [IN_W:0] YMIN = ~YMAX;
   localparam logic [OUT_W-1:0]     OMAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0]     OMIN = {1'b1, {(OUT_W-1){1'b0}}};

   // One extra bit of headroom so adding the rounding constant never wraps.
   function automatic logic signed [IN_W:0] shr(input logic [IN_W-1:0] x);
      logic signed [IN_W:0] e;
      e = $signed({x[IN_W-1], x}) + RND;
      return e >>> SHIFT;
   endfunction

   // Returns {sat, value}.
   function automatic logic [OUT_W:0] clamp(input logic signed [IN_W:0] y);
      return (y > YMAX) ? {1'b1, OMAX} : (y < YMIN) ? {1'b1, OMIN} : {1'b0, y[OUT_W-1:0]};
   endfunction

   logic [IN_W-1:0]        in_x [4];
   logic signed [IN_W:0]   s1_q [4];
   logic signed [IN_W:0]   s1_d [4];
   logic [OUT_W-1:0]       s2_q [4];
   logic [OUT_W-1:0]       s2_d [4];
   logic [3:0]             sat_q, sat_d;
   logic                   s1_v_q, s2_v_q;
   logic                   sticky_q, sticky_d;
   logic                   en, xfer;

   assign in_x = '{in_q0, in_q1, in_q2, in_q3};

   for (genvar i = 0; i < 4; i++) begin : g_comp
      assign s1_d[i] = shr(in_x[i]);
      assign {sat_d[i], s2_d[i]} = clamp(s1_q[i]);
   end

   assign en       = !s2_v_q || out_ready;
   assign xfer     = s2_v_q && out_ready;
   assign in_ready = en;
   assign sticky_d = (xfer && |sat_q) || (sticky_q && !sat_clr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q   <= 1'b0;
         s2_v_q   <= 1'b0;
         s1_q     <= '{default: '0};
         s2_q     <= '{default: '0};
         sat_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         if (en) begin
            s1_v_q <= in_valid;
            s2_v_q <= s1_v_q;
            if (in_valid) s1_q <= s1_d;
            // Outputs only change when a real quaternion moves in, so bubbles keep the last data.
            if (s1_v_q) begin
               s2_q  <= s2_d;
               sat_q <= sat_d;
            end
         end
         sticky_q <= sticky_d;
      end
   end

   assign out_valid  = s2_v_q;
   assign out_q0     = s2_q[0];
   assign out_q1     = s2_q[1];
   assign out_q2     = s2_q[2];
   assign out_q3     = s2_q[3];
   assign out_sat    = sat_q;
   assign sat_sticky = sticky_q;

`ifdef QREQ_SAT_COUNT_EN
   logic [15:0] cnt_q, cnt_d;
   logic [16:0] cnt_sum;

   assign cnt_sum = {1'b0, cnt_q} + 17'(sat_q[0]) + 17'(sat_q[1]) + 17'(sat_q[2]) + 17'(sat_q[3]);
   assign cnt_d   = sat_clr ? '0 : !xfer ? cnt_q : cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign sat_count = cnt_q;
`endif
endmodule
